reset_sequencer: RTL and testbench

- Orders reset release across N_DOM downstream reset domains, all in the clk_i domain.
- On power-on or on a reset request, all domain resets assert together. They then release one domain at a time, in index order 0..N_DOM-1.
- Each release waits a minimum gap and for the previous domain's ready acknowledge, with a timeout fallback.
- The asynchronous request input passes through an internal 2-flop synchronizer (both flops reset to 0).
- Sits between the top-level reset input and the per-subsystem reset nets.

---
 rtl/reset_sequencer.sv | 135 +++++++++++++
 tb/tb_reset_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset release sequencer: asserts all domain resets together, then releases
// them in index order, gated by a minimum gap, per-domain ready and a timeout.
module reset_sequencer #(
    parameter int N_DOM          = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rst_req_i,
    input  logic [N_DOM-1:0] dom_ready_i,
    output logic [N_DOM-1:0] dom_rstn_o,
    output logic             seq_done_o,
    output logic [N_DOM-1:0] timeout_err_o,
    output logic             busy_o
);

    localparam int CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_DOM - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_MIN  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    hold_cnt, hold_cnt_n, hold_inc;
    logic [CW-1:0]    w, w_n, w_inc;
    logic [IW-1:0]    idx, idx_n, idx_inc;
    logic [1:0]       sync;
    logic             req_s;
    logic [N_DOM-1:0] rstn_n, err_n;
    logic             done_n, busy_n;
    logic             ready_sel, at_gap, at_to;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], rst_req_i};
        end
    end

    assign req_s = sync[1];

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        w_n        = w;
        idx_n      = idx;
        rstn_n     = dom_rstn_o;
        err_n      = timeout_err_o;
        done_n     = seq_done_o;
        busy_n     = busy_o;
        hold_inc   = hold_cnt + 1'b1;
        w_inc      = w + 1'b1;
        idx_inc    = idx + 1'b1;
        ready_sel  = dom_ready_i[idx];
        at_gap     = (w_inc >= GAP_MIN);
        at_to      = (w_inc == TO_END);

        case (state)
            S_HOLD: begin
                hold_cnt_n = hold_inc;
                if (hold_inc == HOLD_END) begin
                    rstn_n[0] = 1'b1;
                    idx_n     = '0;
                    w_n       = '0;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_n = (w == TO_END) ? w : w_inc;
                if ((at_gap && ready_sel) || at_to) begin
                    if (at_to && !ready_sel) begin
                        err_n[idx] = 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_DONE;
                    end else begin
                        rstn_n[idx_inc] = 1'b1;
                        idx_n           = idx_inc;
                        w_n             = '0;
                    end
                end
            end
            default: ;
        endcase

        // A request overrides any same-edge advance, including its timeout flag.
        if (req_s) begin
            state_n    = S_HOLD;
            hold_cnt_n = '0;
            w_n        = '0;
            idx_n      = '0;
            rstn_n     = '0;
            err_n      = timeout_err_o;
            done_n     = 1'b0;
            busy_n     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= S_HOLD;
            hold_cnt      <= '0;
            w             <= '0;
            idx           <= '0;
            dom_rstn_o    <= '0;
            timeout_err_o <= '0;
            seq_done_o    <= 1'b0;
            busy_o        <= 1'b1;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_cnt_n;
            w             <= w_n;
            idx           <= idx_n;
            dom_rstn_o    <= rstn_n;
            timeout_err_o <= err_n;
            seq_done_o    <= done_n;
            busy_o        <= busy_n;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected outputs come from a closed-form
// release schedule computed from ready-rise times and request timing.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int TO   = 64;
    localparam int INF  = 1 << 20;

    logic         clk = 1'b0;
    logic         rstn_i = 1'b0;
    logic         rst_req_i = 1'b0;
    logic [N-1:0] dom_ready_i = '0;
    logic [N-1:0] dom_rstn_o;
    logic         seq_done_o;
    logic [N-1:0] timeout_err_o;
    logic         busy_o;

    reset_sequencer #(
        .N_DOM(N),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn_i),
        .rst_req_i(rst_req_i),
        .dom_ready_i(dom_ready_i),
        .dom_rstn_o(dom_rstn_o),
        .seq_done_o(seq_done_o),
        .timeout_err_o(timeout_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] rstn;
        logic         done;
        logic [N-1:0] err;
        logic         busy;
    } obs_t;

    typedef struct packed {
        int   sc;
        int   ed;
        obs_t o;
    } item_t;

    typedef struct {
        int rel[N];
        int done_t;
        int flg[N];
    } sched_t;

    item_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Scenario description: edge at which each ready rises, request edge k and length L.
    int     rdy_t[N];
    bit     has_req;
    int     k, len, ncyc, a1, a2;
    sched_t sa, sb;

    // Sequence whose hold counting starts at edge s.
    function automatic sched_t schedule(input int s);
        sched_t r;
        int t, e;
        t = s + HOLD - 1;
        r.rel[0] = t;
        r.done_t = INF;
        for (int d = 0; d < N; d++) begin
            r.flg[d] = INF;
            if (rdy_t[d] <= t + TO) begin
                e = (rdy_t[d] > t + GAP) ? rdy_t[d] : t + GAP;
            end else begin
                e = t + TO;
                r.flg[d] = e;
            end
            if (d < N - 1) r.rel[d+1] = e;
            else           r.done_t = e;
            t = e;
        end
        return r;
    endfunction

    function automatic obs_t expect_at(input int e);
        obs_t o;
        o = '0;
        if (!has_req || e < a1) begin
            for (int d = 0; d < N; d++) begin
                o.rstn[d] = (e >= sa.rel[d]);
                o.err[d]  = (e >= sa.flg[d]);
            end
            o.done = (e >= sa.done_t);
        end else if (e <= a2) begin
            for (int d = 0; d < N; d++) o.err[d] = (sa.flg[d] < a1);
        end else begin
            for (int d = 0; d < N; d++) begin
                o.rstn[d] = (e >= sb.rel[d]);
                o.err[d]  = (sa.flg[d] < a1) || (e >= sb.flg[d]);
            end
            o.done = (e >= sb.done_t);
        end
        o.busy = !o.done;
        return o;
    endfunction

    always @(posedge clk) begin
        item_t it;
        obs_t  got;
        #1;
        if (exp_q.size() > 0) begin
            it  = exp_q.pop_front();
            got = '{rstn: dom_rstn_o, done: seq_done_o, err: timeout_err_o, busy: busy_o};
            vectors++;
            if (got !== it.o) begin
                miscompares++;
                $display("FAIL outputs sc %0d edge %0d: got rstn=%b done=%b err=%b busy=%b, expected rstn=%b done=%b err=%b busy=%b",
                         it.sc, it.ed, got.rstn, got.done, got.err, got.busy,
                         it.o.rstn, it.o.done, it.o.err, it.o.busy);
            end
        end
    end

    task automatic run_scenario(input int sc);
        item_t it;
        // Async reset lands between edges; outputs must clear without a clock.
        @(posedge clk);
        #3;
        rstn_i = 1'b0;
        #1;
        vectors++;
        if (dom_rstn_o !== '0 || seq_done_o !== 1'b0 || timeout_err_o !== '0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset sc %0d: got rstn=%b done=%b err=%b busy=%b, expected 000 0 000 1",
                     sc, dom_rstn_o, seq_done_o, timeout_err_o, busy_o);
        end
        @(negedge clk);
        dom_ready_i = '0;
        rst_req_i   = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;

        a1 = k + 2;
        a2 = k + len + 1;
        sa = schedule(1);
        sb = schedule(a2 + 1);

        for (int e = 1; e <= ncyc; e++) begin
            if (e > 1) @(negedge clk);
            for (int d = 0; d < N; d++) dom_ready_i[d] = (e >= rdy_t[d]);
            rst_req_i = has_req && (e >= k) && (e < k + len);
            it.sc = sc;
            it.ed = e;
            it.o  = expect_at(e);
            exp_q.push_back(it);
            @(posedge clk);
        end
    endtask

    task automatic set_fixed(input int r0, input int r1, input int r2,
                             input bit rq, input int kk, input int ll, input int nc);
        rdy_t[0] = r0;
        rdy_t[1] = r1;
        rdy_t[2] = r2;
        has_req  = rq;
        k        = kk;
        len      = ll;
        ncyc     = nc;
    endtask

    initial begin
        // Directed cases: nominal, ready stall, timeout, mid-sequence request,
        // held request from DONE, truncated mid-WAIT then power-on repeat.
        set_fixed(1, 1, 1, 1'b0, 0, 0, 40);    run_scenario(0);
        set_fixed(30, 1, 1, 1'b0, 0, 0, 60);   run_scenario(1);
        set_fixed(1, INF, 1, 1'b0, 0, 0, 120); run_scenario(2);
        set_fixed(1, 1, 1, 1'b1, 13, 1, 60);   run_scenario(3);
        set_fixed(1, 1, 1, 1'b1, 25, 20, 90);  run_scenario(4);
        set_fixed(1, INF, 1, 1'b0, 0, 0, 40);  run_scenario(5);
        set_fixed(1, 1, 1, 1'b0, 0, 0, 40);    run_scenario(6);

        for (int sc = 7; sc < 31; sc++) begin
            for (int d = 0; d < N; d++) begin
                case ($urandom_range(0, 3))
                    0:       rdy_t[d] = 1;
                    1:       rdy_t[d] = int'($urandom_range(1, 60));
                    2:       rdy_t[d] = int'($urandom_range(60, 250));
                    default: rdy_t[d] = INF;
                endcase
            end
            ncyc    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 150)) : 360;
            k       = int'($urandom_range(3, 100));
            len     = int'($urandom_range(1, 20));
            has_req = ($urandom_range(0, 1) == 1) && (k + len + 2 <= ncyc);
            run_scenario(sc);
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
